// File: rtl/risc16_pkg.sv
// risc16_pkg: shared RiSC-16 opcodes, instruction constants and loader state type
package risc16_pkg;
  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_LUI  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_LW   = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_JALR = 3'd7;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam logic [15:0] HALT_WORD_DEF = 16'hE071;
  typedef enum logic [1:0] {LOAD, READY, RUN, HALT} imem_state_t;
endpackage

// File: rtl/imem_array.sv
// imem_array: instruction storage with one synchronous write port and one asynchronous read port
module imem_array #(
  parameter int p_DEPTH = 1024,
  parameter int p_AW = $clog2(p_DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [p_AW-1:0] i_waddr,
  input  logic [15:0]     i_wdata,
  input  logic [p_AW-1:0] i_raddr,
  output logic [15:0]     o_rdata
);
  logic [15:0] r_mem [p_DEPTH];
  always_ff @(posedge i_clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction memory, runs the core and freezes it on the halt word
module imem_loader
  import risc16_pkg::*;
#(
  parameter int          p_INST_MEM_SIZE = 1024,
  parameter logic [15:0] p_HALT_WORD     = HALT_WORD_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_valid,
  output logic        o_ld_ready,
  input  logic [15:0] i_ld_data,
  input  logic        i_ld_last,
  input  logic        i_start,
  input  logic [15:0] i_pc,
  output logic [15:0] o_inst,
  output logic        o_core_rst,
  output logic        o_core_en,
  output logic        o_halted,
  output logic        o_err,
  output logic [15:0] o_load_count,
  output logic [31:0] o_exec_count
);
  localparam int AW = $clog2(p_INST_MEM_SIZE);
  imem_state_t r_state, w_next;
  logic [AW-1:0] r_load_addr;
  logic [15:0] w_rdata, r_load_count;
  logic [31:0] r_exec_count;
  logic w_accept, w_last_addr, w_in_range, w_halt;
  logic r_core_rst, r_core_en, r_err;
  imem_array #(.p_DEPTH(p_INST_MEM_SIZE)) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_waddr (r_load_addr),
    .i_wdata (i_ld_data),
    .i_raddr (i_pc[AW-1:0]),
    .o_rdata (w_rdata)
  );
  always_ff @(posedge i_clk)
    r_state <= i_rst ? LOAD : w_next;
  always_comb
    w_next = (w_accept && (i_ld_last || w_last_addr)) ? READY :
             (r_state == READY && i_start) ? RUN :
             w_halt ? HALT : r_state;
  always_comb begin
    w_in_range  = {1'b0, i_pc} < 17'(p_INST_MEM_SIZE);
    o_ld_ready  = r_state == LOAD;
    o_halted    = r_state == HALT;
    o_inst      = (r_state == RUN && w_in_range) ? w_rdata : NOP_WORD;
    w_accept    = o_ld_ready && i_ld_valid;
    w_last_addr = r_load_addr == AW'(p_INST_MEM_SIZE - 1);
    w_halt      = r_state == RUN && o_inst == p_HALT_WORD;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_load_addr  <= '0;
      r_load_count <= '0;
      r_exec_count <= '0;
      r_err        <= 1'b0;
      r_core_rst   <= 1'b1;
      r_core_en    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_load_addr  <= r_load_addr + AW'(1);
        r_load_count <= r_load_count + 16'd1;
      end
      if ((w_accept && !i_ld_last && w_last_addr) || (r_state == RUN && !w_in_range)) r_err <= 1'b1;
      r_exec_count <= r_state == READY ? '0 :
                      r_state == RUN ? r_exec_count + 32'(r_exec_count != '1) : r_exec_count;
      r_core_rst   <= w_next == LOAD || w_next == READY;
      r_core_en    <= w_next == RUN;
    end
  assign o_core_rst   = r_core_rst;
  assign o_core_en    = r_core_en;
  assign o_err        = r_err;
  assign o_load_count = r_load_count;
  assign o_exec_count = r_exec_count;
endmodule
